// File: rtl/pkt_bus_pkg.sv
// Shared packet-bus definitions: framer state encoding and default control codes
// used by both the transmit framer and receiver-side blocks.
package pkt_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_TRAILER = 2'd3
    } tx_state_e;

    localparam logic [7:0] HDR_CTRL_DEFAULT = 8'hFF;
    localparam logic [7:0] EOP_CTRL_DEFAULT = 8'h01;
    localparam logic [7:0] PAYLOAD_CTRL     = 8'h00;

    // Trailer word carries the payload length in its low byte
    function automatic logic [63:0] trailer_word(input logic [7:0] len);
        return {56'd0, len};
    endfunction

endpackage

// File: rtl/pkt_fifo.sv
// Single-clock payload FIFO with show-ahead read data and an occupancy count.
// A write while full is accepted only when a read frees a slot on the same edge.
module pkt_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             wr_accept_s;
    logic             rd_accept_s;
    logic             full_s;
    logic             empty_s;

    assign full_s      = (count_q == CW'(DEPTH));
    assign empty_s     = (count_q == {CW{1'b0}});
    assign rd_accept_s = rd_en && !empty_s;
    assign wr_accept_s = wr_en && (!full_s || rd_accept_s);

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_accept_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_accept_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({wr_accept_s, rd_accept_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (wr_accept_s) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;
    assign full    = full_s;
    assign empty   = empty_s;

endmodule

// File: rtl/pkt_tx_framer.sv
// Packet transmit framer: wraps queued payload words with a header word and a
// length-carrying trailer word, pacing every emitted word by out_rdy.
module pkt_tx_framer
    import pkt_bus_pkg::*;
#(
    parameter int         FIFO_DEPTH = 16,
    parameter logic [7:0] HDR_CTRL   = HDR_CTRL_DEFAULT,
    parameter logic [7:0] EOP_CTRL   = EOP_CTRL_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] pl_data,
    input  logic        pl_wr,
    output logic        pl_full,
    input  logic [63:0] hdr_data,
    input  logic        send,
    output logic        busy,
    output logic [63:0] out_data,
    output logic [7:0]  out_ctrl,
    output logic        out_wr,
    input  logic        out_rdy,
    output logic [31:0] pkts_sent
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    tx_state_e          state_q, state_d;
    logic [63:0]        hdr_q, hdr_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic [63:0]        out_data_q, out_data_d;
    logic [7:0]         out_ctrl_q, out_ctrl_d;
    logic               out_wr_q, out_wr_d;
    logic [31:0]        pkts_q, pkts_d;

    logic               pop_s;
    logic [63:0]        fifo_rd_data_s;
    logic [CNT_W-1:0]   fifo_count_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;

    pkt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .wr_en   (pl_wr),
        .wr_data (pl_data),
        .rd_en   (pop_s),
        .rd_data (fifo_rd_data_s),
        .count   (fifo_count_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    // Framing FSM: next state, bus word and FIFO pop; idle bus drives zeros
    always_comb begin
        state_d    = state_q;
        hdr_d      = hdr_q;
        len_d      = len_q;
        rem_d      = rem_q;
        out_data_d = 64'd0;
        out_ctrl_d = 8'h00;
        out_wr_d   = 1'b0;
        pkts_d     = pkts_q;
        pop_s      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // len snapshots the count now; later writes wait for the next packet
                if (send && !fifo_empty_s) begin
                    hdr_d   = hdr_data;
                    len_d   = fifo_count_s;
                    rem_d   = fifo_count_s;
                    state_d = ST_HDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HDR: begin
                if (out_rdy) begin
                    out_data_d = hdr_q;
                    out_ctrl_d = HDR_CTRL;
                    out_wr_d   = 1'b1;
                    state_d    = ST_PAYLOAD;
                end else begin
                    state_d    = ST_HDR;
                end
            end
            ST_PAYLOAD: begin
                if (out_rdy) begin
                    out_data_d = fifo_rd_data_s;
                    out_ctrl_d = PAYLOAD_CTRL;
                    out_wr_d   = 1'b1;
                    pop_s      = 1'b1;
                    rem_d      = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = ST_TRAILER;
                    end else begin
                        state_d = ST_PAYLOAD;
                    end
                end else begin
                    state_d = ST_PAYLOAD;
                end
            end
            ST_TRAILER: begin
                if (out_rdy) begin
                    out_data_d = trailer_word(8'(len_q));
                    out_ctrl_d = EOP_CTRL;
                    out_wr_d   = 1'b1;
                    pkts_d     = pkts_q + 32'd1;
                    state_d    = ST_IDLE;
                end else begin
                    state_d    = ST_TRAILER;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Framing state and registered bus outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            hdr_q      <= 64'd0;
            len_q      <= {CNT_W{1'b0}};
            rem_q      <= {CNT_W{1'b0}};
            out_data_q <= 64'd0;
            out_ctrl_q <= 8'h00;
            out_wr_q   <= 1'b0;
            pkts_q     <= 32'd0;
        end else begin
            state_q    <= state_d;
            hdr_q      <= hdr_d;
            len_q      <= len_d;
            rem_q      <= rem_d;
            out_data_q <= out_data_d;
            out_ctrl_q <= out_ctrl_d;
            out_wr_q   <= out_wr_d;
            pkts_q     <= pkts_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign pl_full   = fifo_full_s;
    assign out_data  = out_data_q;
    assign out_ctrl  = out_ctrl_q;
    assign out_wr    = out_wr_q;
    assign pkts_sent = pkts_q;

endmodule

// File: tb/tb_pkt_tx_framer.sv
// Bench for pkt_tx_framer: table of directed packets plus randomized traffic,
// all checked against a queue-based packet model.
module tb_pkt_tx_framer;

    localparam int         DEPTH = 16;
    localparam logic [7:0] HDR_C = 8'hFF;
    localparam logic [7:0] EOP_C = 8'h01;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] pl_data = 64'd0;
    logic        pl_wr = 1'b0;
    logic        pl_full;
    logic [63:0] hdr_data = 64'd0;
    logic        send = 1'b0;
    logic        busy;
    logic [63:0] out_data;
    logic [7:0]  out_ctrl;
    logic        out_wr;
    logic        out_rdy = 1'b1;
    logic [31:0] pkts_sent;

    always #5 clk = ~clk;

    pkt_tx_framer #(
        .FIFO_DEPTH (DEPTH),
        .HDR_CTRL   (HDR_C),
        .EOP_CTRL   (EOP_C)
    ) dut (
        .clk       (clk),
        .reset     (rst_n),
        .pl_data   (pl_data),
        .pl_wr     (pl_wr),
        .pl_full   (pl_full),
        .hdr_data  (hdr_data),
        .send      (send),
        .busy      (busy),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .out_wr    (out_wr),
        .out_rdy   (out_rdy),
        .pkts_sent (pkts_sent)
    );

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  ctrl;
    } word_t;

    typedef struct {
        int          nwr;
        logic [63:0] hdr;
        bit          toggle;
        int          late_at;
        int          late_cnt;
        bit          exp_full;
        int          exp_words;
        int          exp_lat;
        int          exp_span;
        logic [63:0] exp_trailer;
    } vec_t;

    word_t       exp_q[$];
    logic [63:0] mq[$];
    int          model_pkts = 0;
    int          checks = 0;
    int          errors = 0;
    vec_t        vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, want);
        end
    endtask

    function automatic word_t mk(input logic [63:0] d, input logic [7:0] c);
        word_t w;
        w.data = d;
        w.ctrl = c;
        return w;
    endfunction

    function automatic int pl_left();
        int n = 0;
        foreach (exp_q[i]) if (exp_q[i].ctrl == 8'h00) n++;
        return n;
    endfunction

    // Packet-level model of what the coming clock edge does with the current inputs
    task automatic model_edge();
        bit pop_now;
        int n;
        pop_now = out_rdy && (exp_q.size() > 0) && (exp_q[0].ctrl == 8'h00);
        n = mq.size();
        if (send && exp_q.size() == 0 && n > 0) begin
            exp_q.push_back(mk(hdr_data, HDR_C));
            for (int i = 0; i < n; i++) exp_q.push_back(mk(mq.pop_front(), 8'h00));
            exp_q.push_back(mk(64'(n), EOP_C));
        end
        if (pl_wr && ((mq.size() + pl_left() < DEPTH) || pop_now)) mq.push_back(pl_data);
    endtask

    task automatic tick();
        bit    rdy_b;
        word_t e;
        rdy_b = out_rdy;
        model_edge();
        @(posedge clk);
        #1;
        if (!rdy_b) chk("no_wr_after_rdy0", 64'(out_wr), 64'd0);
        if (out_wr) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got data %h ctrl %h, required no word", out_data, out_ctrl);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", out_data, e.data);
                chk("out_ctrl", 64'(out_ctrl), 64'(e.ctrl));
                if (e.ctrl == EOP_C) begin
                    model_pkts++;
                    chk("pkts_sent", {32'd0, pkts_sent}, {32'd0, 32'(model_pkts)});
                end
            end
        end
        chk("busy", 64'(busy), 64'(exp_q.size() != 0));
    endtask

    task automatic run_pkt(input vec_t v);
        int cyc, nw, first, last, j;
        logic [63:0] trl;
        for (int i = 0; i < v.nwr; i++) begin
            pl_wr   = 1'b1;
            pl_data = {$urandom, $urandom};
            tick();
        end
        pl_wr = 1'b0;
        chk("pl_full", 64'(pl_full), 64'(v.exp_full));
        hdr_data = v.hdr;
        send     = 1'b1;
        tick();
        send  = 1'b0;
        cyc   = 1;
        nw    = 0;
        first = -1;
        last  = -1;
        trl   = 64'hDEAD;
        j     = 0;
        while (exp_q.size() != 0 && j < 100) begin
            out_rdy = v.toggle ? (j % 2 == 0) : 1'b1;
            pl_wr   = (v.late_cnt > 0) && (j >= v.late_at) && (j < v.late_at + v.late_cnt);
            pl_data = {$urandom, $urandom};
            tick();
            cyc++;
            if (out_wr) begin
                nw++;
                if (first < 0) first = cyc;
                last = cyc;
                if (out_ctrl == EOP_C) trl = out_data;
            end
            j++;
        end
        pl_wr   = 1'b0;
        out_rdy = 1'b1;
        chk("pkt_drained", 64'(exp_q.size()), 64'd0);
        chk("word_count", 64'(nw), 64'(v.exp_words));
        chk("first_latency", 64'(first), 64'(v.exp_lat));
        chk("span", 64'(last - first + 1), 64'(v.exp_span));
        chk("trailer", trl, v.exp_trailer);
    endtask

    task automatic drain();
        int j = 0;
        send    = 1'b0;
        pl_wr   = 1'b0;
        out_rdy = 1'b1;
        while (exp_q.size() != 0 && j < 100) begin
            tick();
            j++;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        //          nwr hdr                      tgl at cnt full words lat span trailer
        vecs[0] = '{3,  64'h1111_2222_3333_4444, 0,  0, 0,  0,   5,    2,  5,   64'h3};
        vecs[1] = '{1,  64'hA5A5_0000_0000_0001, 0,  0, 0,  0,   3,    2,  3,   64'h1};
        vecs[2] = '{4,  64'hCAFE_F00D_0000_0004, 1,  0, 0,  0,   6,    2,  11,  64'h4};
        vecs[3] = '{17, 64'h0F0F_0F0F_0F0F_0F0F, 0,  1, 1,  1,   18,   2,  18,  64'h10};
        vecs[4] = '{0,  64'h0000_0000_0000_00B4, 0,  0, 0,  0,   3,    2,  3,   64'h1};
        vecs[5] = '{2,  64'h5555_AAAA_5555_AAAA, 0,  2, 2,  0,   4,    2,  4,   64'h2};
        vecs[6] = '{0,  64'h7777_0000_0000_0006, 0,  0, 0,  0,   4,    2,  4,   64'h2};

        #22;
        chk("rst_out_wr", 64'(out_wr), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_ctrl", 64'(out_ctrl), 64'd0);
        chk("rst_pkts", {32'd0, pkts_sent}, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_full", 64'(pl_full), 64'd0);
        rst_n = 1'b1;

        for (int k = 0; k < 7; k++) run_pkt(vecs[k]);

        // send with nothing queued is ignored
        send = 1'b1;
        tick();
        send = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        chk("empty_send_pkts", {32'd0, pkts_sent}, 64'd7);

        // reset asserted mid-payload aborts the packet and empties the FIFO
        for (int k = 0; k < 4; k++) begin
            pl_wr   = 1'b1;
            pl_data = {$urandom, $urandom};
            tick();
        end
        pl_wr    = 1'b0;
        hdr_data = 64'h1234_5678_9ABC_DEF0;
        send     = 1'b1;
        tick();
        send = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_wr", 64'(out_wr), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_out_data", out_data, 64'd0);
        exp_q.delete();
        mq.delete();
        model_pkts = 0;
        #3;
        rst_n = 1'b1;
        chk("post_rst_full", 64'(pl_full), 64'd0);
        chk("post_rst_pkts", {32'd0, pkts_sent}, 64'd0);
        send = 1'b1;
        tick();
        send = 1'b0;
        for (int k = 0; k < 3; k++) tick();

        // randomized traffic
        for (int k = 0; k < 500; k++) begin
            out_rdy  = ($urandom_range(0, 3) != 0);
            pl_wr    = ($urandom_range(0, 2) == 0);
            pl_data  = {$urandom, $urandom};
            send     = ($urandom_range(0, 5) == 0);
            hdr_data = {$urandom, $urandom};
            tick();
        end
        drain();
        if (mq.size() != 0) begin
            send = 1'b1;
            tick();
            drain();
        end
        chk("model_empty", 64'(mq.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
